// File: rtl/color_correct_matrix_pkg.sv
// Shared types/constants for the 3x3 colour correction matrix; also carries the
// stream dtype macros when no earlier file has defined them.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH        8
`define DTYPE_FRAME_START  8'h01
`define DTYPE_FRAME_END    8'h02
`define DTYPE_ROW_START    8'h04
`define DTYPE_ROW_END      8'h08
`define DTYPE_PIXEL        8'h10
`define DTYPE_PIXEL_MASK   8'hF0
`endif

package color_correct_matrix_pkg;
  // entry (row o, col i) sits at index 3*o+i; 0=r, 1=g, 2=b
  localparam int CCM_RR = 0, CCM_RG = 1, CCM_RB = 2;
  localparam int CCM_GR = 3, CCM_GG = 4, CCM_GB = 5;
  localparam int CCM_BR = 6, CCM_BG = 7, CCM_BB = 8;
  localparam int CCM_COEFF_FRAC = 8;
  localparam int CCM_ONE        = 1 << CCM_COEFF_FRAC;
  localparam int CCM_STAGES     = 3;

  function automatic bit ccm_diag(input int idx);
    return (idx == CCM_RR) || (idx == CCM_GG) || (idx == CCM_BB);
  endfunction
endpackage

// File: rtl/color_correct_matrix_channel.sv
// One CCM output row: 3 signed multiplies, sum, round, optional offset
// (CCM_OFFSET_EN), clamp. Products and sum are registered; round/clamp is comb.
module ccm_channel
  import color_correct_matrix_pkg::*;
#(
  parameter int PIXEL_WIDTH = 10,
  parameter int COEFF_WIDTH = 12,
  parameter int COEFF_FRAC  = 8
) (
  input  logic                              clk,
  input  logic                              resetb,
  input  logic [2:0][PIXEL_WIDTH-1:0]       pix,
  input  logic [2:0][COEFF_WIDTH-1:0]       coef,
`ifdef CCM_OFFSET_EN
  input  logic signed [PIXEL_WIDTH:0]       offset,
`endif
  output logic [PIXEL_WIDTH-1:0]            res
);
  localparam int PW = PIXEL_WIDTH + COEFF_WIDTH + 1;
  localparam int SW = PW + 2;
  localparam int RW = SW + 1;
  localparam logic signed [RW-1:0] HALF = RW'(2**(COEFF_FRAC-1));
  localparam logic signed [RW-1:0] PMAX = RW'(2**PIXEL_WIDTH - 1);

  logic [2:0][PW-1:0]    prod;
  logic signed [SW-1:0]  sum;
  logic signed [RW-1:0]  shifted, adj;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      prod <= '0;
      sum  <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        prod[i] <= PW'($signed({1'b0, pix[i]})) * PW'($signed(coef[i]));
      sum <= SW'($signed(prod[0])) + SW'($signed(prod[1])) + SW'($signed(prod[2]));
    end
  end

`ifdef CCM_OFFSET_EN
  // offset rides with the beat so a later frame's capture cannot leak in
  logic signed [PIXEL_WIDTH:0] off_s1, off_s2;
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      off_s1 <= '0;
      off_s2 <= '0;
    end else begin
      off_s1 <= offset;
      off_s2 <= off_s1;
    end
  end
`endif

  always_comb begin
    shifted = (RW'(sum) + HALF) >>> COEFF_FRAC;
`ifdef CCM_OFFSET_EN
    adj = shifted + RW'(off_s2);
`else
    adj = shifted;
`endif
    if (adj < 0)          res = '0;
    else if (adj > PMAX)  res = '1;
    else                  res = adj[PIXEL_WIDTH-1:0];
  end
endmodule

// File: rtl/color_correct_matrix.sv
// 3x3 colour correction matrix, fixed 3-cycle latency, coefficients shadowed at
// FRAME_START. Define CCM_OFFSET_EN for per-channel post-shift offsets.
module color_correct_matrix
  import color_correct_matrix_pkg::*;
#(
  parameter int PIXEL_WIDTH = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 12,
  parameter int COEFF_FRAC  = 8
) (
  input  logic                         clk,
  input  logic                         resetb,
  input  logic                         enable,
  input  logic                         dvi,
  input  logic [`DTYPE_WIDTH-1:0]      dtypei,
  input  logic [PIXEL_WIDTH-1:0]       ri,
  input  logic [PIXEL_WIDTH-1:0]       gi,
  input  logic [PIXEL_WIDTH-1:0]       bi,
  input  logic [DATA_WIDTH-1:0]        meta_datai,
  input  logic [9*COEFF_WIDTH-1:0]     coeffs,
`ifdef CCM_OFFSET_EN
  input  logic signed [PIXEL_WIDTH:0]  offset_r,
  input  logic signed [PIXEL_WIDTH:0]  offset_g,
  input  logic signed [PIXEL_WIDTH:0]  offset_b,
`endif
  output logic                         dvo,
  output logic [PIXEL_WIDTH-1:0]       r,
  output logic [PIXEL_WIDTH-1:0]       g,
  output logic [PIXEL_WIDTH-1:0]       b,
  output logic [`DTYPE_WIDTH-1:0]      dtypeo,
  output logic [DATA_WIDTH-1:0]        meta_datao
);
  localparam int STAGES = CCM_STAGES;

  logic [8:0][COEFF_WIDTH-1:0]                  coef_act;
  logic [STAGES:1]                              vld_pipe;
  logic [STAGES:1][`DTYPE_WIDTH-1:0]            dtype_pipe;
  logic [STAGES:1][DATA_WIDTH-1:0]              meta_pipe;
  logic [STAGES-1:1]                            en_pipe;
  logic [STAGES-1:1][2:0][PIXEL_WIDTH-1:0]      raw_pipe;
  logic [2:0][PIXEL_WIDTH-1:0]                  pix_in, ch_res, rgb_q;
  logic                                         capture, pix_upd;

  assign pix_in  = {bi, gi, ri};
  assign capture = dvi && (dtypei == `DTYPE_FRAME_START);
  assign pix_upd = vld_pipe[STAGES-1] &&
                   ((dtype_pipe[STAGES-1] & `DTYPE_PIXEL_MASK) != '0);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < 9; i++)
        coef_act[i] <= ccm_diag(i) ? COEFF_WIDTH'(1 << COEFF_FRAC) : '0;
    end else if (capture) begin
      coef_act <= coeffs;
    end
  end

`ifdef CCM_OFFSET_EN
  logic [2:0][PIXEL_WIDTH:0] off_act;
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)      off_act <= '0;
    else if (capture) off_act <= {offset_b, offset_g, offset_r};
  end
`endif

  for (genvar o = 0; o < 3; o++) begin : g_ch
    ccm_channel #(
      .PIXEL_WIDTH (PIXEL_WIDTH),
      .COEFF_WIDTH (COEFF_WIDTH),
      .COEFF_FRAC  (COEFF_FRAC)
    ) u_ch (
      .clk    (clk),
      .resetb (resetb),
      .pix    (pix_in),
      .coef   (coef_act[3*o +: 3]),
`ifdef CCM_OFFSET_EN
      .offset ($signed(off_act[o])),
`endif
      .res    (ch_res[o])
    );
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      vld_pipe   <= '0;
      dtype_pipe <= '0;
      meta_pipe  <= '0;
      en_pipe    <= '0;
      raw_pipe   <= '0;
      rgb_q      <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[STAGES-1:1], dvi};
      dtype_pipe <= {dtype_pipe[STAGES-1:1], dtypei};
      meta_pipe  <= {meta_pipe[STAGES-1:1], meta_datai};
      en_pipe    <= {en_pipe[STAGES-2:1], enable};
      raw_pipe   <= {raw_pipe[STAGES-2:1], pix_in};
      // non-pixel beats pass through without disturbing the held colour
      if (pix_upd)
        rgb_q <= en_pipe[STAGES-1] ? ch_res : raw_pipe[STAGES-1];
    end
  end

  assign dvo        = vld_pipe[STAGES];
  assign dtypeo     = dtype_pipe[STAGES];
  assign meta_datao = meta_pipe[STAGES];
  assign r          = rgb_q[0];
  assign g          = rgb_q[1];
  assign b          = rgb_q[2];
endmodule
